// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if : issue/result bundle between the EX stage and muldiv_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             hi_sel;
   logic             busy;
   logic [WIDTH-1:0] out;

   modport master (
      output start, op, a, b, cancel, hi_sel,
      input  busy, out
   );

   modport slave (
      input  start, op, a, b, cancel, hi_sel,
      output busy, out
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit : multi-cycle multiply/divide with private HI/LO, MAC and cancel
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module muldiv_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic           clk,
   input  logic           reset,
   muldiv_unit_if.slave   bus
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   localparam logic [1:0] MODE_SET = 2'd0;
   localparam logic [1:0] MODE_ADD = 2'd1;
   localparam logic [1:0] MODE_SUB = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_pend;
   logic [1:0]           r_mode;
   logic                 r_dz;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_launch;
   logic                 w_is_mul;
   logic                 w_is_div;
   logic                 w_signed;
   logic [1:0]           w_mode;
   logic                 w_commit;
   logic [2*WIDTH-1:0]   w_a_ext;
   logic [2*WIDTH-1:0]   w_b_ext;
   logic [2*WIDTH-1:0]   w_prod;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH-1:0]     w_b_div;
   logic [WIDTH-1:0]     w_q_mag;
   logic [WIDTH-1:0]     w_r_mag;
   logic [WIDTH-1:0]     w_q;
   logic [WIDTH-1:0]     w_r;

   assign w_launch = bus.start && !bus.cancel && (r_state == S_IDLE);
   assign w_is_mul = bus.op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   assign w_is_div = bus.op inside {OP_DIV, OP_DIVU};
   assign w_signed = bus.op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
   assign w_mode   = (bus.op inside {OP_MADD, OP_MADDU}) ? MODE_ADD :
                     (bus.op inside {OP_MSUB, OP_MSUBU}) ? MODE_SUB : MODE_SET;
   assign w_commit = (r_state != S_IDLE) && (r_cnt == '0) && !bus.cancel;

   // One 2W x 2W multiplier serves both signednesses via operand extension.
   assign w_a_ext = {{WIDTH{w_signed & bus.a[WIDTH-1]}}, bus.a};
   assign w_b_ext = {{WIDTH{w_signed & bus.b[WIDTH-1]}}, bus.b};
   assign w_prod  = w_a_ext * w_b_ext;

   // Sign-magnitude divide; most-negative / -1 falls out as the required wrap.
   assign w_a_neg = w_signed & bus.a[WIDTH-1];
   assign w_b_neg = w_signed & bus.b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -bus.a : bus.a;
   assign w_b_mag = w_b_neg ? -bus.b : bus.b;
   assign w_b_div = (w_b_mag == '0) ? WIDTH'(1) : w_b_mag;
   assign w_q_mag = w_a_mag / w_b_div;
   assign w_r_mag = w_a_mag % w_b_div;
   assign w_q     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
   assign w_r     = w_a_neg ? -w_r_mag : w_r_mag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_launch && w_is_mul) begin
               w_state_nxt = S_MUL;
            end else if (w_launch && w_is_div) begin
               w_state_nxt = S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            if (bus.cancel || (r_cnt == '0)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_pend <= '0;
         r_mode <= MODE_SET;
         r_dz   <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else if (w_launch) begin
         r_pend <= w_is_div ? {w_r, w_q} : w_prod;
         r_mode <= w_is_div ? MODE_SET : w_mode;
         r_dz   <= w_is_div && (bus.b == '0);
         r_cnt  <= w_is_div ? DIV_CNT : MUL_CNT;
         if (bus.op == OP_MTHI) begin
            r_hi <= bus.a;
         end
         if (bus.op == OP_MTLO) begin
            r_lo <= bus.a;
         end
      end else if (r_state != S_IDLE) begin
         r_cnt <= r_cnt - CNT_W'(1);
         // Accumulate uses HI/LO at completion, which cannot move while busy.
         if (w_commit) begin
            if (r_state == S_DIV) begin
               if (!r_dz) begin
                  {r_hi, r_lo} <= r_pend;
               end
            end else begin
               case (r_mode)
                  MODE_ADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
                  MODE_SUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
                  default:  {r_hi, r_lo} <= r_pend;
               endcase
            end
         end
      end
   end

   assign bus.busy = (r_state != S_IDLE);
   assign bus.out  = bus.hi_sel ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit : directed plus randomized bench with a behavioural HI/LO model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_unit;
   localparam int W  = 32;
   localparam int ML = 5;
   localparam int DL = 10;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus();

   muldiv_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [W-1:0] m_a  = '0;
   logic [W-1:0] m_b  = '0;
   logic [3:0]   m_op = '0;
   int           m_left = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Full-precision reference arithmetic on 64-bit integers.
   function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [63:0] acc);
      logic   sgn;
      longint xa, xb;
      logic [63:0] p, q, r;
      sgn = (op == 4'd0) || (op == 4'd2) || (op == 4'd6) || (op == 4'd8);
      xa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      xb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      p   = xa * xb;
      case (op)
         4'd0, 4'd1: return p;
         4'd6, 4'd7: return acc + p;
         4'd8, 4'd9: return acc - p;
         4'd2, 4'd3: begin
            if (b == 32'd0) return acc;
            q = xa / xb;
            r = xa % xb;
            return {r[31:0], q[31:0]};
         end
         default: return acc;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_left <= 0;
      end else if (m_left != 0) begin
         if (bus.cancel) begin
            m_left <= 0;
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) {m_hi, m_lo} <= model_result(m_op, m_a, m_b, {m_hi, m_lo});
         end
      end else if (bus.start && !bus.cancel) begin
         m_op <= bus.op;
         m_a  <= bus.a;
         m_b  <= bus.b;
         case (bus.op)
            4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9: m_left <= ML;
            4'd2, 4'd3: m_left <= DL;
            4'd4: m_hi <= bus.a;
            4'd5: m_lo <= bus.a;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en && reset) begin
         check("busy_vs_model", {63'd0, bus.busy}, {63'd0, (m_left != 0)});
         check("out_vs_model", {32'd0, bus.out}, {32'd0, (bus.hi_sel ? m_hi : m_lo)});
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk); #1;
      end
      if (bus.busy) check("busy_timeout", 64'd1, 64'd0);
   endtask

   task automatic expect_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
      bus.hi_sel = 1'b1; #1;
      check({name, "_hi"}, {32'd0, bus.out}, {32'd0, hi});
      bus.hi_sel = 1'b0; #1;
      check({name, "_lo"}, {32'd0, bus.out}, {32'd0, lo});
   endtask

   initial begin
      int n;
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      bus.cancel = 1'b0; bus.hi_sel = 1'b0;
      repeat (3) @(negedge clk);
      #3 reset = 1'b1;
      @(negedge clk); #1;
      cmp_en = 1'b1;
      check("reset_busy", {63'd0, bus.busy}, 64'd0);
      expect_hilo("reset", 32'h0, 32'h0);

      issue(4'd0, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      check("mult_busy_cycles", 64'(n), 64'd5);
      expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      issue(4'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check("div_busy_cycles", 64'(n), 64'd10);
      expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      issue(4'd3, 32'd7, 32'd2);
      wait_idle(n);
      expect_hilo("divu", 32'd1, 32'd3);
      issue(4'd2, 32'd99, 32'd0);
      wait_idle(n);
      check("div0_busy_cycles", 64'(n), 64'd10);
      expect_hilo("div0", 32'd1, 32'd3);

      issue(4'd4, 32'd0, 32'd0);
      issue(4'd5, 32'hFFFF_FFFF, 32'd0);
      check("mtlo_busy", {63'd0, bus.busy}, 64'd0);
      issue(4'd7, 32'd1, 32'd1);
      wait_idle(n);
      expect_hilo("maddu", 32'd1, 32'd0);
      issue(4'd8, 32'd1, 32'd1);
      wait_idle(n);
      expect_hilo("msub", 32'd0, 32'hFFFF_FFFF);

      issue(4'd0, 32'd3, 32'd4);
      @(negedge clk); #1;
      bus.start = 1'b1; bus.op = 4'd4; bus.a = 32'h1234;
      @(negedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b1;
      @(negedge clk); #1;
      bus.cancel = 1'b0;
      check("cancel_busy", {63'd0, bus.busy}, 64'd0);
      expect_hilo("cancel", 32'd0, 32'hFFFF_FFFF);

      issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

      issue(4'd0, 32'd5, 32'd6);
      @(negedge clk); #2;
      reset = 1'b0; #1;
      check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
      expect_hilo("rst_mid", 32'd0, 32'd0);
      @(negedge clk); #3 reset = 1'b1;

      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         bus.start  = ($urandom_range(0, 2) != 0);
         bus.op     = 4'($urandom_range(0, 15));
         bus.a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       bus.b = 32'd0;
            1:       bus.b = 32'hFFFF_FFFF;
            2:       bus.b = 32'($urandom_range(1, 9));
            default: bus.b = $urandom;
         endcase
         bus.cancel = ($urandom_range(0, 19) == 0);
         bus.hi_sel = 1'($urandom);
      end
      @(negedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      wait_idle(n);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
